sipo: RTL and testbench



---
 rtl/serdes_pkg.sv | 12 +
 rtl/sipo_bit_counter.sv | 40 ++++
 rtl/sipo.sv | 67 ++++++
 tb/tb_sipo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared constants for the SerDes receive path.
package serdes_pkg;

  // Width of one 8b/10b code group.
  localparam int SYMBOL_WIDTH = 10;

  // K28.5 comma code groups in RX parallel order: the first bit received
  // (bit 'a' of abcdei fghj) sits at bit 0.
  localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDN = 10'b0101111100;
  localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDP = 10'b1010000011;

endpackage : serdes_pkg

// File: rtl/sipo_bit_counter.sv
// Bit position counter: counts 0..WIDTH-1 and wraps. The terminal-count
// flag marks the edge that samples the last bit of a word.
module sipo_bit_counter
  import serdes_pkg::*;
#(
  parameter int WIDTH = SYMBOL_WIDTH
) (
  input  logic clk,
  input  logic rst,
  output logic last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: wrap on the last bit of the word, otherwise advance.
  always_comb begin
    count_d = count_q;
    if (count_q == LAST_CNT) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register; reset restarts the word boundary at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_CNT);

endmodule : sipo_bit_counter

// File: rtl/sipo.sv
// Serial-to-parallel converter for the RX chain. Word boundaries are set by
// reset release only; there is no comma alignment here.
module sipo
  import serdes_pkg::*;
#(
  parameter int WIDTH     = SYMBOL_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             BitCLK,
  input  logic             Reset,
  input  logic             Serial,
  output logic [WIDTH-1:0] RxParallel_10
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] rx_d;
  logic             word_last_s;

  // Insert one bit so that, after WIDTH shifts, the first bit of the word
  // ends up at bit 0 (LSB first) or at bit WIDTH-1 (MSB first).
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic            b);
    logic [WIDTH-1:0] res;
    if (LSB_FIRST) begin
      res = {b, cur[WIDTH-1:1]};
    end else begin
      res = {cur[WIDTH-2:0], b};
    end
    return res;
  endfunction

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk  (BitCLK),
    .rst  (Reset),
    .last (word_last_s)
  );

  // Next shift contents and output word; the output captures the word
  // including the bit sampled on the completing edge.
  always_comb begin
    shift_d = shift_in(shift_q, Serial);
    rx_d    = rx_q;
    if (word_last_s) begin
      rx_d = shift_d;
    end else begin
      rx_d = rx_q;
    end
  end

  // Shift and output registers; reset discards any partial word.
  always_ff @(posedge BitCLK) begin
    if (Reset) begin
      shift_q <= {WIDTH{1'b0}};
      rx_q    <= {WIDTH{1'b0}};
    end else begin
      shift_q <= shift_d;
      rx_q    <= rx_d;
    end
  end

  assign RxParallel_10 = rx_q;

endmodule : sipo

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: a driver issues one bit (or reset) per edge and
// pushes the expected output of both an LSB-first and an MSB-first build;
// a monitor pops and compares on every falling edge.
module tb_sipo;
  import serdes_pkg::*;

  localparam int W = SYMBOL_WIDTH;

  typedef struct {
    logic [W-1:0] exp_lsb;
    logic [W-1:0] exp_msb;
    string        tag;
  } exp_t;

  logic         bit_clk;
  logic         reset_s;
  logic         serial_s;
  logic [W-1:0] rx_lsb_s;
  logic [W-1:0] rx_msb_s;

  exp_t sb_q[$];
  bit   bits_q[$];
  logic [W-1:0] model_lsb;
  logic [W-1:0] model_msb;

  int n_checks;
  int n_pass;

  sipo #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .BitCLK        (bit_clk),
    .Reset         (reset_s),
    .Serial        (serial_s),
    .RxParallel_10 (rx_lsb_s)
  );

  sipo #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .BitCLK        (bit_clk),
    .Reset         (reset_s),
    .Serial        (serial_s),
    .RxParallel_10 (rx_msb_s)
  );

  initial bit_clk = 1'b0;
  always #5 bit_clk = ~bit_clk;

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: collect bits, and every WIDTH bits form a word in
  // arrival order; reset throws away the collected bits and zeroes the output.
  task automatic do_edge(input logic r, input logic s, input string tag);
    exp_t e;
    @(negedge bit_clk);
    #1;
    reset_s  = r;
    serial_s = s;
    @(posedge bit_clk);
    #1;
    if (r) begin
      bits_q.delete();
      model_lsb = '0;
      model_msb = '0;
    end else begin
      bits_q.push_back(s);
      if (bits_q.size() == W) begin
        for (int k = 0; k < W; k++) begin
          model_lsb[k]       = bits_q[k];
          model_msb[W-1-k]   = bits_q[k];
        end
        bits_q.delete();
      end
    end
    e.exp_lsb = model_lsb;
    e.exp_msb = model_msb;
    e.tag     = tag;
    sb_q.push_back(e);
  endtask

  task automatic send_word(input logic [W-1:0] w, input string tag);
    for (int k = 0; k < W; k++) begin
      do_edge(1'b0, w[k], tag);
    end
  endtask

  // Monitor: every edge's expected output is compared on the falling edge.
  always @(negedge bit_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, "_lsb"}, rx_lsb_s, e.exp_lsb);
      check({e.tag, "_msb"}, rx_msb_s, e.exp_msb);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] w_k;
    n_checks  = 0;
    n_pass    = 0;
    model_lsb = '0;
    model_msb = '0;
    reset_s   = 1'b1;
    serial_s  = 1'b0;

    // 1: reset held two edges with Serial toggling, then ten zero bits.
    do_edge(1'b1, 1'b1, "rst_hold");
    do_edge(1'b1, 1'b0, "rst_hold");
    check("rst_value", rx_lsb_s, 10'h000);
    for (int i = 0; i < W; i++) do_edge(1'b0, 1'b0, "zeros");
    check("zeros_word", rx_lsb_s, 10'h000);

    // 2: K28.5 RD- bit sequence a..j = 0,0,1,1,1,1,1,0,1,0.
    do_edge(1'b1, 1'b0, "rst");
    w_k = K28_5_RDN;
    send_word(w_k, "k285");
    check("k285_lsb_const", rx_lsb_s, 10'b0101111100);
    check("k285_msb_const", rx_msb_s, 10'b0011111010);
    for (int i = 0; i < W - 1; i++) do_edge(1'b0, 1'($urandom_range(0, 1)), "k285_hold");
    check("k285_hold_const", rx_lsb_s, 10'b0101111100);

    // 3: back-to-back words with no gap.
    do_edge(1'b1, 1'b0, "rst");
    send_word(10'h3FF, "b2b_3ff");
    check("b2b_3ff_const", rx_lsb_s, 10'h3FF);
    send_word(10'h155, "b2b_155");
    check("b2b_155_const", rx_lsb_s, 10'h155);

    // 4: reset in the middle of a word.
    for (int i = 0; i < 6; i++) do_edge(1'b0, 1'b1, "partial");
    do_edge(1'b1, 1'b1, "mid_rst");
    check("mid_rst_const", rx_lsb_s, 10'h000);
    send_word(10'h2AA, "after_rst");
    check("after_rst_const", rx_lsb_s, 10'h2AA);

    // Reset on the edge that would complete a word: reset wins.
    do_edge(1'b1, 1'b0, "rst");
    for (int i = 0; i < W - 1; i++) do_edge(1'b0, 1'b1, "pre_cmp");
    do_edge(1'b1, 1'b1, "rst_on_cmp");
    check("rst_on_cmp_const", rx_lsb_s, 10'h000);

    // 5: random stream of 100 bits.
    do_edge(1'b1, 1'b0, "rst");
    for (int i = 0; i < 100; i++) do_edge(1'b0, 1'($urandom_range(0, 1)), "random");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge bit_clk);
    #2;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sipo
